// File: rtl/ctrl_sequencer.sv
// Multi-cycle Moore control sequencer for the 32-bit mini-SRC datapath.
// Fetch/decode/execute T-states with ready handshakes, wait timeout, single-step and clean stop.
module ctrl_sequencer #(
    parameter int NREGS    = 16,
    parameter int LINK_REG = 15,
    parameter int TIMEOUT  = 64
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [31:0]      IR,
    input  logic             MemReady,
    input  logic             AluDone,
    input  logic             CON,
    input  logic             Stop,
    input  logic             StepMode,
    input  logic             Step,
    output logic             PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin,
    output logic             ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin, HIout, LOout,
    output logic             Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Inportout, Outportin, AluStart,
    output logic [NREGS-1:0] R_enableIn,
    output logic             Run,
    output logic             Fault,
    output logic [7:0]       State
);

    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [7:0] {
        S_RESET = 8'h00, S_F0  = 8'h01, S_F1  = 8'h02, S_F2  = 8'h03, S_DEC = 8'h04,
        S_R3    = 8'h05, S_R4  = 8'h06, S_I4  = 8'h07, S_R5  = 8'h08,
        S_M3    = 8'h09, S_M4  = 8'h0A, S_MW  = 8'h0B, S_M5  = 8'h0C, S_M6  = 8'h0D,
        S_U3    = 8'h0E, S_U4  = 8'h0F,
        S_L3    = 8'h10, S_L4  = 8'h11, S_L5  = 8'h12, S_L6  = 8'h13, S_L7  = 8'h14,
        S_LI5   = 8'h15, S_S6  = 8'h16, S_S7  = 8'h17,
        S_B3    = 8'h18, S_B4  = 8'h19, S_B5  = 8'h1A, S_B6  = 8'h1B,
        S_J     = 8'h1C, S_JL3 = 8'h1D, S_JL4 = 8'h1E,
        S_IN    = 8'h1F, S_OUT = 8'h20, S_MFHI = 8'h21, S_MFLO = 8'h22, S_NOP = 8'h23,
        S_PAUSE = 8'h24, S_HALT = 8'h25, S_FAULT = 8'h26
    } state_t;

    state_t         state, state_nx, boundary_nx;
    logic [CW-1:0]  wait_cnt;
    logic [4:0]     opcode;
    logic           in_wait, ready, timed_out;
    logic           unused_ir_bits;

    assign opcode         = IR[31:27];
    assign unused_ir_bits = ^IR[26:0];

    always_comb begin
        in_wait   = (state == S_F1) || (state == S_L6) || (state == S_S7) || (state == S_MW);
        ready     = (state == S_MW) ? AluDone : MemReady;
        // Fault on the low-ready cycle that would bring the count up to TIMEOUT.
        timed_out = (TIMEOUT > 0) && in_wait && !ready && (wait_cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_RESET;
            wait_cnt <= '0;
        end else begin
            state <= state_nx;
            if (!in_wait || ready)
                wait_cnt <= '0;
            else if (wait_cnt != '1)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    always_comb begin
        boundary_nx = Stop ? S_HALT : (StepMode ? S_PAUSE : S_F0);
        state_nx    = state;
        unique case (state)
            S_RESET: state_nx = S_F0;
            S_F0:    state_nx = S_F1;
            S_F1:    state_nx = ready ? S_F2 : (timed_out ? S_FAULT : S_F1);
            S_F2:    state_nx = S_DEC;
            S_DEC: begin
                case (opcode)
                    5'b00000, 5'b00001, 5'b00010: state_nx = S_L3;
                    5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                    5'b01000, 5'b01001, 5'b01010, 5'b01011,
                    5'b01100, 5'b01101, 5'b01110: state_nx = S_R3;
                    5'b01111, 5'b10000:           state_nx = S_M3;
                    5'b10001, 5'b10010:           state_nx = S_U3;
                    5'b10011:                     state_nx = S_B3;
                    5'b10100:                     state_nx = S_J;
                    5'b10101:                     state_nx = S_JL3;
                    5'b10110:                     state_nx = S_IN;
                    5'b10111:                     state_nx = S_OUT;
                    5'b11000:                     state_nx = S_MFHI;
                    5'b11001:                     state_nx = S_MFLO;
                    5'b11010:                     state_nx = S_NOP;
                    5'b11011:                     state_nx = S_HALT;
                    default:                      state_nx = S_FAULT;
                endcase
            end
            S_R3:  state_nx = (opcode == 5'b01100 || opcode == 5'b01101 || opcode == 5'b01110) ? S_I4 : S_R4;
            S_R4, S_I4: state_nx = S_R5;
            S_M3:  state_nx = S_M4;
            S_M4:  state_nx = S_MW;
            S_MW:  state_nx = ready ? S_M5 : (timed_out ? S_FAULT : S_MW);
            S_M5:  state_nx = S_M6;
            S_U3:  state_nx = S_U4;
            S_L3:  state_nx = S_L4;
            S_L4:  state_nx = (opcode == 5'b00001) ? S_LI5 : S_L5;
            S_L5:  state_nx = (opcode == 5'b00010) ? S_S6 : S_L6;
            S_L6:  state_nx = ready ? S_L7 : (timed_out ? S_FAULT : S_L6);
            S_S6:  state_nx = S_S7;
            S_S7:  state_nx = ready ? boundary_nx : (timed_out ? S_FAULT : S_S7);
            S_B3:  state_nx = S_B4;
            S_B4:  state_nx = S_B5;
            S_B5:  state_nx = S_B6;
            S_JL3: state_nx = S_JL4;
            S_R5, S_M6, S_U4, S_L7, S_LI5, S_B6, S_J, S_JL4,
            S_IN, S_OUT, S_MFHI, S_MFLO, S_NOP: state_nx = boundary_nx;
            S_PAUSE: state_nx = Stop ? S_HALT : (Step ? S_F0 : S_PAUSE);
            S_HALT:  state_nx = S_HALT;
            S_FAULT: state_nx = S_FAULT;
            default: state_nx = S_FAULT;
        endcase
    end

    always_comb begin
        {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin} = '0;
        {ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin, HIout, LOout} = '0;
        {Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Inportout, Outportin, AluStart} = '0;
        R_enableIn = '0;
        case (state)
            S_F0:   begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; PCin = 1'b1; end
            S_F1, S_L6: begin Read = 1'b1; MDRin = 1'b1; end
            S_F2:   begin MDRout = 1'b1; IRin = 1'b1; end
            S_R3, S_M3: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
            S_R4:   begin Grc = 1'b1; Rout = 1'b1; ZlowIn = 1'b1; ZhighIn = 1'b1; end
            S_I4, S_L4, S_B5: begin Cout = 1'b1; ZlowIn = 1'b1; ZhighIn = 1'b1; end
            S_R5, S_U4, S_LI5: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_M4:   begin Grc = 1'b1; Rout = 1'b1; AluStart = 1'b1; end
            S_MW:   begin Grc = 1'b1; Rout = 1'b1; ZlowIn = AluDone; ZhighIn = AluDone; end
            S_M5:   begin Zlowout = 1'b1; LOin = 1'b1; end
            S_M6:   begin Zhighout = 1'b1; HIin = 1'b1; end
            S_U3:   begin Grb = 1'b1; Rout = 1'b1; ZlowIn = 1'b1; ZhighIn = 1'b1; end
            S_L3:   begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_L5:   begin Zlowout = 1'b1; MARin = 1'b1; end
            S_L7:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_S6:   begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
            S_S7:   begin MDRout = 1'b1; Write = 1'b1; end
            S_B3:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
            S_B4:   begin PCout = 1'b1; Yin = 1'b1; end
            S_B6:   begin Zlowout = 1'b1; PCin = CON; end
            S_J, S_JL4: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
            S_JL3:  begin PCout = 1'b1; R_enableIn[LINK_REG] = 1'b1; end
            S_IN:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_OUT:  begin Gra = 1'b1; Rout = 1'b1; Outportin = 1'b1; end
            S_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            S_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            default: ;
        endcase
    end

    assign Run   = !(state == S_RESET || state == S_HALT || state == S_FAULT || state == S_PAUSE);
    assign Fault = (state == S_FAULT);
    assign State = state;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Table-driven bench for ctrl_sequencer: per-cycle input/expected-output records, plus a
// hand-written pause/stop sequence.
module tb_ctrl_sequencer;

    logic        Clock = 1'b0;
    logic        Reset, MemReady, AluDone, CON, Stop, StepMode, Step;
    logic [31:0] IR;
    logic        PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin;
    logic        ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic        Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Inportout, Outportin, AluStart;
    logic [15:0] R_enableIn;
    logic        Run, Fault;
    logic [7:0]  State;

    always #5 Clock = ~Clock;

    ctrl_sequencer #(.NREGS(16), .LINK_REG(15), .TIMEOUT(4)) dut (
        .Clock(Clock), .Reset(Reset), .IR(IR), .MemReady(MemReady), .AluDone(AluDone),
        .CON(CON), .Stop(Stop), .StepMode(StepMode), .Step(Step),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .Yin(Yin),
        .ZlowIn(ZlowIn), .ZhighIn(ZhighIn), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .CONin(CONin), .Inportout(Inportout), .Outportin(Outportin),
        .AluStart(AluStart), .R_enableIn(R_enableIn), .Run(Run), .Fault(Fault), .State(State)
    );

    localparam logic [30:0] M_PCOUT = 31'd1 << 0,  M_PCIN  = 31'd1 << 1,  M_INCPC = 31'd1 << 2;
    localparam logic [30:0] M_MARIN = 31'd1 << 3,  M_MDRIN = 31'd1 << 4,  M_MDROUT = 31'd1 << 5;
    localparam logic [30:0] M_READ  = 31'd1 << 6,  M_WRITE = 31'd1 << 7,  M_IRIN  = 31'd1 << 8;
    localparam logic [30:0] M_YIN   = 31'd1 << 9,  M_ZLI   = 31'd1 << 10, M_ZHI   = 31'd1 << 11;
    localparam logic [30:0] M_ZLO   = 31'd1 << 12, M_ZHO   = 31'd1 << 13, M_HIIN  = 31'd1 << 14;
    localparam logic [30:0] M_LOIN  = 31'd1 << 15, M_HIOUT = 31'd1 << 16, M_LOOUT = 31'd1 << 17;
    localparam logic [30:0] M_GRA   = 31'd1 << 18, M_GRB   = 31'd1 << 19, M_GRC   = 31'd1 << 20;
    localparam logic [30:0] M_RIN   = 31'd1 << 21, M_ROUT  = 31'd1 << 22, M_BAOUT = 31'd1 << 23;
    localparam logic [30:0] M_COUT  = 31'd1 << 24, M_CONIN = 31'd1 << 25, M_INPO  = 31'd1 << 26;
    localparam logic [30:0] M_OUTPI = 31'd1 << 27, M_ALUST = 31'd1 << 28, R       = 31'd1 << 29;
    localparam logic [30:0] M_FAULT = 31'd1 << 30;

    // Debug encoding of the State port for the states the bench names explicitly.
    localparam logic [7:0] ST_RESET = 8'h00, ST_F0 = 8'h01, ST_NOP = 8'h23;
    localparam logic [7:0] ST_PAUSE = 8'h24, ST_HALT = 8'h25, ST_FAULT = 8'h26, ST_X = 8'hFF;

    typedef struct {
        string       name;
        logic        rst, mr, ad, con, stop, sm, step;
        logic [31:0] ir;
        logic [30:0] exp;
        logic [7:0]  st;
        logic [15:0] ren;
    } vec_t;

    vec_t        vecs[$];
    logic        c_rst, c_mr, c_ad, c_con, c_stop, c_sm, c_step;
    logic [31:0] c_ir;
    int          errors = 0;
    int          checks = 0;
    logic [30:0] act;

    function automatic void v(string nm, logic [30:0] exp, logic [7:0] st = ST_X, logic [15:0] ren = 16'h0);
        vec_t r;
        r.name = nm; r.rst = c_rst; r.mr = c_mr; r.ad = c_ad; r.con = c_con;
        r.stop = c_stop; r.sm = c_sm; r.step = c_step; r.ir = c_ir;
        r.exp = exp; r.st = st; r.ren = ren;
        vecs.push_back(r);
    endfunction

    function automatic void fetch(string nm);
        v({nm, ".F0"}, M_PCOUT | M_MARIN | M_INCPC | M_PCIN | R, ST_F0);
        v({nm, ".F1"}, M_READ | M_MDRIN | R);
        v({nm, ".F2"}, M_MDROUT | M_IRIN | R);
        v({nm, ".DEC"}, R);
    endfunction

    always_comb act = {Fault, Run, AluStart, Outportin, Inportout, CONin, Cout, BAout, Rout, Rin,
                       Grc, Grb, Gra, LOout, HIout, LOin, HIin, Zhighout, Zlowout, ZhighIn, ZlowIn,
                       Yin, IRin, Write, Read, MDRout, MDRin, MARin, IncPC, PCin, PCout};

    task automatic check_vec(input string nm, input logic [30:0] exp, input logic [7:0] st, input logic [15:0] ren);
        checks++;
        if (act !== exp || R_enableIn !== ren || (st != ST_X && State !== st)) begin
            errors++;
            $display("FAIL %s: outputs=%h en=%h state=%h, required outputs=%h en=%h state=%h",
                     nm, act, R_enableIn, State, exp, ren, st);
        end
    endtask

    task automatic check_state(input string nm, input logic [7:0] st, input logic run_exp);
        checks++;
        if (State !== st || Run !== run_exp) begin
            errors++;
            $display("FAIL %s: state=%h run=%b, required state=%h run=%b", nm, State, Run, st, run_exp);
        end
    endtask

    initial begin
        c_rst = 0; c_mr = 1; c_ad = 0; c_con = 0; c_stop = 0; c_sm = 0; c_step = 0; c_ir = '0;

        v("reset", 31'd0, ST_RESET);
        c_ir = 32'h1989_0000; fetch("add");
        v("add.R3", M_GRB | M_ROUT | M_YIN | R);
        v("add.R4", M_GRC | M_ROUT | M_ZLI | M_ZHI | R);
        v("add.R5", M_ZLO | M_GRA | M_RIN | R);
        c_ir = 32'h0123_0004; fetch("ld");
        v("ld.L3", M_GRB | M_BAOUT | M_YIN | R);
        v("ld.L4", M_COUT | M_ZLI | M_ZHI | R);
        v("ld.L5", M_ZLO | M_MARIN | R);
        c_mr = 0;
        for (int i = 0; i < 3; i++) v("ld.L6wait", M_READ | M_MDRIN | R);
        c_mr = 1;
        v("ld.L6rdy", M_READ | M_MDRIN | R);
        v("ld.L7", M_MDROUT | M_GRA | M_RIN | R);
        c_ir = 32'h0800_0000; fetch("ldi");
        v("ldi.L3", M_GRB | M_BAOUT | M_YIN | R);
        v("ldi.L4", M_COUT | M_ZLI | M_ZHI | R);
        v("ldi.LI5", M_ZLO | M_GRA | M_RIN | R);
        c_ir = 32'h1000_0000; fetch("st");
        v("st.L3", M_GRB | M_BAOUT | M_YIN | R);
        v("st.L4", M_COUT | M_ZLI | M_ZHI | R);
        v("st.L5", M_ZLO | M_MARIN | R);
        v("st.S6", M_GRA | M_ROUT | M_MDRIN | R);
        c_mr = 0; v("st.S7wait", M_MDROUT | M_WRITE | R);
        c_mr = 1; v("st.S7rdy", M_MDROUT | M_WRITE | R);
        c_ir = 32'h6000_0000; fetch("addi");
        v("addi.R3", M_GRB | M_ROUT | M_YIN | R);
        v("addi.I4", M_COUT | M_ZLI | M_ZHI | R);
        v("addi.R5", M_ZLO | M_GRA | M_RIN | R);
        c_ir = 32'h7800_0000; fetch("mul");
        v("mul.M3", M_GRB | M_ROUT | M_YIN | R);
        v("mul.M4", M_GRC | M_ROUT | M_ALUST | R);
        v("mul.MWwait", M_GRC | M_ROUT | R);
        c_ad = 1; v("mul.MWdone", M_GRC | M_ROUT | M_ZLI | M_ZHI | R);
        c_ad = 0;
        v("mul.M5", M_ZLO | M_LOIN | R);
        v("mul.M6", M_ZHO | M_HIIN | R);
        c_ir = 32'h8800_0000; fetch("neg");
        v("neg.U3", M_GRB | M_ROUT | M_ZLI | M_ZHI | R);
        v("neg.U4", M_ZLO | M_GRA | M_RIN | R);
        c_ir = 32'h9800_0000; fetch("br0");
        v("br0.B3", M_GRA | M_ROUT | M_CONIN | R);
        v("br0.B4", M_PCOUT | M_YIN | R);
        v("br0.B5", M_COUT | M_ZLI | M_ZHI | R);
        v("br0.B6", M_ZLO | R);
        c_con = 1; fetch("br1");
        v("br1.B3", M_GRA | M_ROUT | M_CONIN | R);
        v("br1.B4", M_PCOUT | M_YIN | R);
        v("br1.B5", M_COUT | M_ZLI | M_ZHI | R);
        v("br1.B6", M_ZLO | M_PCIN | R);
        c_con = 0;
        c_ir = 32'hA800_0000; fetch("jal");
        v("jal.JL3", M_PCOUT | R, ST_X, 16'h8000);
        v("jal.JL4", M_GRA | M_ROUT | M_PCIN | R);
        c_ir = 32'hA000_0000; fetch("jr");   v("jr.J", M_GRA | M_ROUT | M_PCIN | R);
        c_ir = 32'hB000_0000; fetch("in");   v("in.X", M_INPO | M_GRA | M_RIN | R);
        c_ir = 32'hB800_0000; fetch("out");  v("out.X", M_GRA | M_ROUT | M_OUTPI | R);
        c_ir = 32'hC000_0000; fetch("mfhi"); v("mfhi.X", M_HIOUT | M_GRA | M_RIN | R);
        c_ir = 32'hC800_0000; fetch("mflo"); v("mflo.X", M_LOOUT | M_GRA | M_RIN | R);
        // Single-step: pause after each nop, Step held two cycles releases one instruction.
        c_ir = 32'hD000_0000; c_sm = 1; fetch("nop1");
        v("nop1.X", R, ST_NOP);
        v("pause1", 31'd0, ST_PAUSE);
        c_step = 1; v("pause1.step", 31'd0, ST_PAUSE);
        v("nop2.F0", M_PCOUT | M_MARIN | M_INCPC | M_PCIN | R, ST_F0);
        c_step = 0;
        v("nop2.F1", M_READ | M_MDRIN | R);
        v("nop2.F2", M_MDROUT | M_IRIN | R);
        v("nop2.DEC", R);
        v("nop2.X", R, ST_NOP);
        v("pause2a", 31'd0, ST_PAUSE);
        v("pause2b", 31'd0, ST_PAUSE);
        c_sm = 0; c_step = 1; v("pause2.step", 31'd0, ST_PAUSE);
        c_step = 0;
        // Stop raised mid-instruction: add completes, then HALT with no further fetch.
        c_ir = 32'h1989_0000; fetch("addS");
        c_stop = 1;
        v("addS.R3", M_GRB | M_ROUT | M_YIN | R);
        v("addS.R4", M_GRC | M_ROUT | M_ZLI | M_ZHI | R);
        v("addS.R5", M_ZLO | M_GRA | M_RIN | R);
        c_stop = 0;
        v("halt1", 31'd0, ST_HALT);
        v("halt2", 31'd0, ST_HALT);
        c_rst = 1; v("halt.rst", 31'd0, ST_HALT);
        c_rst = 0; v("halt.reset", 31'd0, ST_RESET);
        // mul timeout with TIMEOUT=4: AluDone arriving on the 5th MW cycle is too late.
        c_ir = 32'h7800_0000; fetch("mulT");
        v("mulT.M3", M_GRB | M_ROUT | M_YIN | R);
        v("mulT.M4", M_GRC | M_ROUT | M_ALUST | R);
        for (int i = 0; i < 4; i++) v("mulT.MW", M_GRC | M_ROUT | R);
        c_ad = 1;
        v("mulT.fault1", M_FAULT, ST_FAULT);
        v("mulT.fault2", M_FAULT, ST_FAULT);
        c_ad = 0;
        c_rst = 1; v("mulT.rst", M_FAULT, ST_FAULT);
        c_rst = 0; v("mulT.reset", 31'd0, ST_RESET);
        c_ir = 32'hF000_0000; fetch("bad");
        v("bad.fault", M_FAULT, ST_FAULT);
        c_rst = 1; v("bad.rst", M_FAULT, ST_FAULT);
        c_rst = 0; v("bad.reset", 31'd0, ST_RESET);
        // Reset applied mid-wait in L6.
        c_ir = 32'h0123_0004; fetch("ldR");
        v("ldR.L3", M_GRB | M_BAOUT | M_YIN | R);
        v("ldR.L4", M_COUT | M_ZLI | M_ZHI | R);
        v("ldR.L5", M_ZLO | M_MARIN | R);
        c_mr = 0; c_rst = 1; v("ldR.L6rst", M_READ | M_MDRIN | R);
        c_mr = 1; c_rst = 0; v("ldR.reset", 31'd0, ST_RESET);

        Reset = 1; IR = '0; MemReady = 1; AluDone = 0; CON = 0; Stop = 0; StepMode = 0; Step = 0;
        repeat (2) @(posedge Clock);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge Clock);
            Reset = vecs[i].rst; IR = vecs[i].ir; MemReady = vecs[i].mr; AluDone = vecs[i].ad;
            CON = vecs[i].con; Stop = vecs[i].stop; StepMode = vecs[i].sm; Step = vecs[i].step;
            #1;
            check_vec(vecs[i].name, vecs[i].exp, vecs[i].st, vecs[i].ren);
        end

        // Hand-written: Stop while paused goes to HALT and stays there.
        begin
            int n;
            n = 0;
            @(negedge Clock);
            IR = 32'hD000_0000; StepMode = 1;
            #1;
            while (State != ST_PAUSE && n < 20) begin
                @(negedge Clock); #1;
                n++;
            end
            check_state("reach_pause", ST_PAUSE, 1'b0);
            @(negedge Clock);
            Stop = 1;
            @(negedge Clock);
            Stop = 0; StepMode = 0; Step = 1;
            #1;
            check_state("pause_stop", ST_HALT, 1'b0);
            for (int k = 0; k < 3; k++) begin
                @(negedge Clock); #1;
                check_state("halt_hold", ST_HALT, 1'b0);
            end
            Step = 0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised multi-cycle control sequencer for the 32-bit mini-SRC datapath; the next-generation control unit. It fetches, decodes and sequences every instruction class through Moore-decoded T-states, driving the bus, register-file and memory strobes. It adds behaviour the previous unit lacked:
- variable-latency memory and multiply/divide handshakes;
- a wait timeout with fault reporting;
- a single-step mode;
- a clean stop at an instruction boundary;
- conditional branch commit;
- a configurable link register.

## Interface
Parameters:
- NREGS, 16, register-file size; width of R_enableIn.
- LINK_REG, 15, register written by jal (0..NREGS-1).
- TIMEOUT, 64, maximum cycles in any wait state before fault; 0 disables the timeout.

Ports:
- Clock  in  1  system clock; all state changes on posedge.
- Reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- IR  in  32  instruction register; opcode = IR[31:27].
- MemReady  in  1  memory completes read/write this cycle.
- AluDone  in  1  mul/div result valid this cycle.
- CON  in  1  branch condition flip-flop output.
- Stop  in  1  request halt at next instruction boundary.
- StepMode  in  1  single-step enable.
- Step  in  1  advance one instruction while paused.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin, Yin  out  1 each  datapath strobes.
- ZlowIn, ZhighIn, Zlowout, Zhighout, HIin, LOin, HIout, LOout  out  1 each  datapath strobes.
- Gra, Grb, Grc, Rin, Rout, BAout, Cout, CONin, Inportout, Outportin, AluStart  out  1 each  datapath strobes.
- R_enableIn  out  NREGS  direct one-hot register write enable.
- Run  out  1  high in every state except RESET, HALT, FAULT and PAUSE.
- Fault  out  1  sticky error flag.
- State  out  8  current state encoding, for debug.

## Operation
- All outputs are pure Moore decodes of State. Every strobe is 0 unless listed for the current state.
- Fetch sequence:
  - F0: PCout, MARin, IncPC, PCin.
  - F1: Read, MDRin; waits until MemReady.
  - F2: MDRout, IRin.
  - DEC: no strobes; branches on IR[31:27].
- Decode map. Each listed state lasts one cycle unless marked as a wait.
  - add 00011, sub 00100, shr 00101, shra 00110, shl 00111, ror 01000, rol 01001, and 01010, or 01011:
    - R3: Grb, Rout, Yin.
    - R4: Grc, Rout, ZlowIn, ZhighIn.
    - R5: Zlowout, Gra, Rin.
  - addi 01100, andi 01101, ori 01110: as R, except R4 uses Cout in place of Grc/Rout.
  - mul 01111, div 10000:
    - M3: Grb, Rout, Yin.
    - M4: Grc, Rout, AluStart.
    - MW (wait): Grc, Rout; ZlowIn and ZhighIn = AluDone; exits when AluDone.
    - M5: Zlowout, LOin.
    - M6: Zhighout, HIin.
  - neg 10001, not 10010:
    - U3: Grb, Rout, ZlowIn, ZhighIn.
    - U4: Zlowout, Gra, Rin.
  - ld 00000:
    - L3: Grb, BAout, Yin.
    - L4: Cout, ZlowIn, ZhighIn.
    - L5: Zlowout, MARin.
    - L6 (wait): Read, MDRin until MemReady.
    - L7: MDRout, Gra, Rin.
  - ldi 00001: L3, L4, then LI5: Zlowout, Gra, Rin.
  - st 00010:
    - L3, L4, L5.
    - S6: Gra, Rout, MDRin.
    - S7 (wait): MDRout, Write until MemReady.
  - br 10011:
    - B3: Gra, Rout, CONin.
    - B4: PCout, Yin.
    - B5: Cout, ZlowIn, ZhighIn.
    - B6: Zlowout, PCin = CON. The PC is unchanged when CON=0.
  - jr 10100: J: Gra, Rout, PCin.
  - jal 10101:
    - JL3: PCout, R_enableIn = one-hot(LINK_REG).
    - JL4: Gra, Rout, PCin.
  - in 10110: Inportout, Gra, Rin.
  - out 10111: Gra, Rout, Outportin.
  - mfhi 11000: HIout, Gra, Rin.
  - mflo 11001: LOout, Gra, Rin.
  - nop 11010: one empty state.
  - halt 11011: HALT.
  - 11100-11111: FAULT.
- Instruction boundary, evaluated in the last state of each instruction. Priority order:
  1. Stop=1 -> HALT.
  2. StepMode=1 -> PAUSE.
  3. Otherwise -> F0.
- PAUSE: no strobes. Moves to F0 in the cycle after Step=1 is sampled. Stop=1 in PAUSE -> HALT.
- HALT and FAULT are terminal; only Reset leaves them. FAULT sets Fault=1.
- Timeout:
  - The wait counter clears to 0 on entry to F1, L6, S7 and MW, and increments each cycle the ready input is low.
  - With TIMEOUT>0, the count reaching TIMEOUT with ready still low -> FAULT.
  - Counter width is clog2(TIMEOUT+1), minimum 1. It must not wrap.

## Timing
- Reset=1 at a posedge:
  - next State = RESET and Fault = 0; wait counter = 0.
  - all strobes = 0, R_enableIn = 0, Run = 0.
  - Reset overrides every state, including mid-instruction, wait, HALT and FAULT.
- RESET -> F0 on the first clock with Reset=0.
- Zero-wait instruction latency is F0..DEC (4 cycles) plus the execute states:
  - R/I-type: 7 cycles.
  - ld: 9 cycles.
  - br: 8 cycles.
  - jr, in, out, mfhi, mflo, nop: 5 cycles.
- Each wait state adds exactly the number of cycles MemReady/AluDone stays low. A ready sampled high on the first cycle adds 0.
- Stop and Step are sampled only at boundary states and in PAUSE. Stop asserted mid-instruction lets that instruction complete.
- Simultaneous ready high and timeout reached in the same cycle: ready wins and no fault is raised.

## Test plan
- add, IR=0x1989_0000, MemReady tied to 1: Run=1 from F0; R5 asserts Zlowout, Gra and Rin in cycle 7 after F0 entry; next state is F0.
- ld with MemReady low for 3 cycles in L6: L6 lasts 4 cycles with Read=MDRin=1 throughout; L7 follows; total 12 cycles.
- br:
  - with CON=0: B6 shows PCin=0.
  - with CON=1: B6 shows PCin=1.
  - jal with LINK_REG=15: JL3 drives R_enableIn=0x8000 for exactly 1 cycle.
- mul with AluDone at the 5th MW cycle and TIMEOUT=4: FAULT, Fault=1, Run=0. Pulsing Reset then returns to RESET, F0 with Fault=0.
- StepMode=1 running nop: PAUSE after each nop; Step held 2 cycles advances exactly one instruction. Stop raised during add R3 gives HALT after R5, with no further F0.
- Opcode 11110: DEC -> FAULT. Reset asserted while in L6 wait: next state RESET with all strobes 0.
